// File: rtl/npc_pkg.sv
// Shared definitions for the fetch PC generator: D-stage control-flow classes
// and the default address map of the instruction memory.
package npc_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NPC_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] NPC_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] NPC_IM_SIZE  = 32'h0000_4000;

endpackage

// File: rtl/npc_target.sv
// Branch, jump and link target arithmetic for the D-stage instruction.
// Purely combinational; zero latency, no flow control.
module npc_target
  import npc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc_d,
  input  logic [15:0]       i_offset,
  input  logic [25:0]       i_instr_index,
  output logic [ADDR_W-1:0] o_br_target,
  output logic [ADDR_W-1:0] o_j_target,
  output logic [ADDR_W-1:0] o_link
);

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_br_off;

  assign w_pc4    = i_pc_d + ADDR_W'(4);
  assign w_br_off = {{(ADDR_W-18){i_offset[15]}}, i_offset, 2'b00};

  assign o_br_target = w_pc4 + w_br_off;
  assign o_link      = i_pc_d + ADDR_W'(8);

  // J keeps the delay-slot region bits; everything above bit 27 comes from pcD+4.
  always_comb begin
    o_j_target       = w_pc4;
    o_j_target[27:0] = {i_instr_index, 2'b00};
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with fixed-priority next-PC selection, fetch address-error flag
// and D-stage flush pulse; one-cycle redirect latency. Define NPC_EXC_EN for CP0 cores.
module pc_gen
  import npc_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NPC_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(NPC_EXC_PC),
  parameter logic [ADDR_W-1:0] IM_BASE  = ADDR_W'(NPC_IM_BASE),
  parameter logic [ADDR_W-1:0] IM_SIZE  = ADDR_W'(NPC_IM_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        npcOp,
  input  logic              cmpOut,
  input  logic [ADDR_W-1:0] pcD,
  input  logic [15:0]       offset,
  input  logic [25:0]       instrIndex,
  input  logic [ADDR_W-1:0] regTarget,
  input  logic              excReq,
  input  logic              eretReq,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pcF,
  output logic [ADDR_W-1:0] pcLink,
  output logic              adelF,
  output logic              flushD
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_adel;
  logic              r_flush;

  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_j_target;
  logic              w_exc_take;
  logic              w_eret_take;

  // The window limit is formed one bit wider so a window ending at 2^ADDR_W still works.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] lim;
    lim = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
    return (a[1:0] != 2'b00) || (a < IM_BASE) || ({1'b0, a} >= lim);
  endfunction

  npc_target #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .i_pc_d        (pcD),
    .i_offset      (offset),
    .i_instr_index (instrIndex),
    .o_br_target   (w_br_target),
    .o_j_target    (w_j_target),
    .o_link        (pcLink)
  );

`ifdef NPC_EXC_EN
  assign w_exc_take  = excReq;
  assign w_eret_take = eretReq & ~excReq;
`else
  // Cores without CP0 keep the ports for a common netlist but never redirect on them.
  logic w_unused_exc;
  assign w_unused_exc = ^{excReq, eretReq, epc};
  assign w_exc_take   = 1'b0;
  assign w_eret_take  = 1'b0;
`endif

  always_comb begin
    w_pc_next = r_pc + ADDR_W'(4);
    if (w_exc_take) begin
      w_pc_next = EXC_PC;
    end else if (w_eret_take) begin
      w_pc_next = epc;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else begin
      case (npcOp)
        NPC_BR:  if (cmpOut) w_pc_next = w_br_target;
        NPC_J:   w_pc_next = w_j_target;
        NPC_JR:  w_pc_next = regTarget;
        default: w_pc_next = r_pc + ADDR_W'(4);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_adel  <= addr_err(RESET_PC);
      r_flush <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_adel  <= addr_err(w_pc_next);
      r_flush <= w_exc_take | w_eret_take;
    end
  end

  assign pcF    = r_pc;
  assign adelF  = r_adel;
  assign flushD = r_flush;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a spec-level reference model checked every cycle.
module tb_pc_gen;

  localparam logic [31:0] RST  = 32'h0000_3000;
  localparam logic [31:0] EXCV = 32'h0000_4180;
  localparam longint      BASE = 64'h3000;
  localparam longint      SIZE = 64'h4000;
`ifdef NPC_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npcOp = 2'd0;
  logic        cmpOut = 1'b0;
  logic [31:0] pcD = 32'h0;
  logic [15:0] offset = 16'h0;
  logic [25:0] instrIndex = 26'h0;
  logic [31:0] regTarget = 32'h0;
  logic        excReq = 1'b0;
  logic        eretReq = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [31:0] pcF;
  logic [31:0] pcLink;
  logic        adelF;
  logic        flushD;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic        m_adel;
  logic        m_flush;
  logic        m_valid = 1'b0;

  pc_gen dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npcOp      (npcOp),
    .cmpOut     (cmpOut),
    .pcD        (pcD),
    .offset     (offset),
    .instrIndex (instrIndex),
    .regTarget  (regTarget),
    .excReq     (excReq),
    .eretReq    (eretReq),
    .epc        (epc),
    .pcF        (pcF),
    .pcLink     (pcLink),
    .adelF      (adelF),
    .flushD     (flushD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit illegal(input logic [31:0] a);
    longint v;
    v = longint'(a);
    return (v % 4 != 0) || (v < BASE) || (v >= BASE + SIZE);
  endfunction

  // Reference model: next fetch PC straight from the priority list.
  always @(posedge clk) begin
    logic [31:0] n;
    logic [31:0] seq_pc;
    seq_pc = m_valid ? m_pc + 32'd4 : 32'hx;
    if (!reset)                   n = RST;
    else if (EXC_EN && excReq)    n = EXCV;
    else if (EXC_EN && eretReq)   n = epc;
    else if (stall)               n = m_pc;
    else if (npcOp == 2'd1 && cmpOut)
      n = pcD + 32'd4 + 32'(longint'($signed(offset)) * 4);
    else if (npcOp == 2'd2)
      n = ((pcD + 32'd4) & 32'hF000_0000) + {4'h0, instrIndex, 2'b00};
    else if (npcOp == 2'd3)       n = regTarget;
    else                          n = seq_pc;
    m_pc    <= n;
    m_adel  <= illegal(n);
    m_flush <= reset && EXC_EN && (excReq || eretReq);
    if (!reset) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pcF", pcF, m_pc);
      chk("adelF", {31'b0, adelF}, {31'b0, m_adel});
      chk("flushD", {31'b0, flushD}, {31'b0, m_flush});
      chk("pcLink", pcLink, pcD + 32'd8);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick();
    chk("reset_pc", pcF, 32'h3000);
    chk("reset_adel", {31'b0, adelF}, 32'd0);
    chk("reset_flush", {31'b0, flushD}, 32'd0);

    reset = 1'b1;
    tick(); chk("seq1", pcF, 32'h3004);
    tick(); chk("seq2", pcF, 32'h3008);
    tick(); chk("seq3", pcF, 32'h300C);
    chk("seq_adel", {31'b0, adelF}, 32'd0);

    pcD = 32'h3004; npcOp = 2'd1; cmpOut = 1'b1; offset = 16'hFFFF;
    tick(); chk("br_taken", pcF, 32'h3004);
    cmpOut = 1'b0;
    tick(); chk("br_not_taken", pcF, 32'h3008);

    pcD = 32'h3008; npcOp = 2'd2; instrIndex = 26'h0000C03;
    #1 chk("link", pcLink, 32'h3010);
    tick(); chk("jump", pcF, 32'h300C);

    npcOp = 2'd3; regTarget = 32'h3002;
    tick(); chk("jr_mis", pcF, 32'h3002);
    chk("jr_mis_adel", {31'b0, adelF}, 32'd1);
    regTarget = 32'h2FFC;
    tick(); chk("jr_low_adel", {31'b0, adelF}, 32'd1);
    regTarget = 32'h3000;
    tick(); chk("jr_ok_adel", {31'b0, adelF}, 32'd0);

    stall = 1'b1; npcOp = 2'd1; cmpOut = 1'b1; offset = 16'h0004;
    tick(); chk("stall1", pcF, 32'h3000);
    tick(); chk("stall2", pcF, 32'h3000);

    excReq = 1'b1;
    tick();
    chk("exc_pc", pcF, EXC_EN ? 32'h4180 : 32'h3000);
    chk("exc_flush", {31'b0, flushD}, EXC_EN ? 32'd1 : 32'd0);
    excReq = 1'b0; stall = 1'b0; npcOp = 2'd0;
    tick();
    chk("after_exc", pcF, EXC_EN ? 32'h4184 : 32'h3004);
    chk("flush_once", {31'b0, flushD}, 32'd0);

    excReq = 1'b1; eretReq = 1'b1; epc = 32'h3010;
    tick(); chk("exc_over_eret", pcF, EXC_EN ? 32'h4180 : 32'h3008);
    excReq = 1'b0;
    tick(); chk("eret", pcF, EXC_EN ? 32'h3010 : 32'h300C);
    eretReq = 1'b0; stall = 1'b1;
    tick(); chk("flush_drops_in_stall", {31'b0, flushD}, 32'd0);

    reset = 1'b0; excReq = 1'b1;
    tick(); chk("reset_in_stall", pcF, 32'h3000);
    chk("reset_flush2", {31'b0, flushD}, 32'd0);
    reset = 1'b1; excReq = 1'b0; stall = 1'b0;

    npcOp = 2'd3; regTarget = 32'hFFFF_FFFC;
    tick(); chk("top_pc", pcF, 32'hFFFF_FFFC);
    npcOp = 2'd0;
    tick(); chk("wrap", pcF, 32'h0);
    chk("wrap_adel", {31'b0, adelF}, 32'd1);

    pcD = 32'h7FFC; npcOp = 2'd1; cmpOut = 1'b1; offset = 16'h8000;
    tick(); chk("br_neg_max", pcF, 32'hFFFE_8000);
    npcOp = 2'd3; regTarget = 32'h6FFC;
    tick(); chk("top_of_window_adel", {31'b0, adelF}, 32'd0);
    npcOp = 2'd0;
    tick(); chk("past_window_adel", {31'b0, adelF}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-stage program-counter generator for the pipelined MIPS core. Holds the registered fetch PC and, each cycle, selects the next PC: sequential, taken branch, J/JAL, JR/JALR, exception entry or ERET. Branch and jump resolution happens in D and uses MIPS delay-slot semantics. Also drives the fetch address-error flag and a D-stage flush pulse.

## Interface
- `ADDR_W`, 32: PC width in bits; arithmetic is modulo 2^ADDR_W.
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `EXC_PC`, 32'h0000_4180: exception entry vector.
- `IM_BASE`, 32'h0000_3000: lowest legal fetch address.
- `IM_SIZE`, 32'h0000_4000: legal fetch window size in bytes.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `stall` input 1: hold `pcF` (hazard stall).
- `npcOp` input 2: D-stage control-flow class; encodings are in the package.
- `cmpOut` input 1: branch condition result for the D-stage instruction.
- `pcD` input ADDR_W: PC of the D-stage instruction.
- `offset` input 16: branch immediate.
- `instrIndex` input 26: J-format index.
- `regTarget` input ADDR_W: forwarded rs value for JR/JALR.
- `excReq` input 1: exception or interrupt taken this cycle.
- `eretReq` input 1: ERET taken this cycle.
- `epc` input ADDR_W: ERET return address.
- `pcF` output ADDR_W: current fetch PC (registered).
- `pcLink` output ADDR_W: `pcD + 8`, combinational; the link value.
- `adelF` output 1: registered; `pcF` is misaligned or outside the legal window.
- `flushD` output 1: registered; one-cycle pulse after an exception or ERET redirect.

## Operation
- Selection uses fixed priority. The first matching case is loaded into `pcF` at the clock edge:
  1. `reset` == 0: load `RESET_PC`.
  2. `excReq`: load `EXC_PC`.
  3. `eretReq`: load `epc`.
  4. `stall`: hold `pcF`.
  5. `npcOp` = BR and `cmpOut` = 1: load `pcD + 4 + sext(offset) << 2`.
  6. `npcOp` = J: load `{(pcD+4)[ADDR_W-1:28], instrIndex, 2'b00}`. Any bits above 31 come from `pcD+4`.
  7. `npcOp` = JR: load `regTarget`, unmodified, including its low bits.
  8. Otherwise (SEQ, or BR with `cmpOut` = 0): load `pcF + 4`. The delay slot at `pcD+4` is already in F.
- `excReq` and `eretReq` override `stall`. Simultaneous `excReq` and `eretReq` resolves to `excReq`.
- `adelF` is computed from the value being loaded into `pcF`, so it always describes the current `pcF`. It is 1 if the value has `[1:0]` ≠ 0, or is < `IM_BASE`, or is ≥ `IM_BASE + IM_SIZE`.
- A misaligned or out-of-window PC is still loaded. `adelF` flags it, and the exception logic responds with `excReq`.
- `flushD` is 1 for exactly the cycle after an `excReq` or `eretReq` redirect was taken. It is 0 otherwise, including while stalled.
- Wrap-around: `pcF + 4` at 0xFFFF_FFFC yields 0, with `adelF` = 1. There is no saturation.

## Timing
- Reset values: `pcF` = `RESET_PC`, `adelF` = 0 (provided `RESET_PC` is legal), `flushD` = 0.
- Reset is sampled only at the clock edge. It overrides every request, including reset asserted mid-stall or in the same cycle as `excReq`.
- Redirect latency is one cycle: a branch resolved in D in cycle n appears on `pcF` in cycle n+1.
- `pcLink` has zero latency, combinational from `pcD`.
- Stall: while `stall` = 1 and there is no exception or ERET, `pcF`, `adelF` and `flushD` are frozen, except that `flushD` drops to 0. A branch presented during a stall is ignored. D re-presents it after the stall.

## Configuration
- `NPC_EXC_EN` defined: priority levels 2–3 and `flushD` behave as above.
- `NPC_EXC_EN` undefined: `excReq`, `eretReq` and `epc` remain ports but are ignored, and `flushD` is tied to 0. This is for the P5/P6 cores without CP0.

## Structure
- `npc_pkg` holds:
  - the `npcOp` encodings: SEQ = 2'd0, BR = 2'd1, J = 2'd2, JR = 2'd3;
  - the default `RESET_PC`, `EXC_PC`, `IM_BASE` and `IM_SIZE` constants.
- One combinational sub-module, `npc_target`, computes the branch, jump and link targets from `pcD`, `offset` and `instrIndex`. `pc_gen` owns the register, priority mux and flags.

## Test plan
- Reset then three free-running cycles: `pcF` = 0x3000, 0x3004, 0x3008, 0x300C; `adelF` = 0 throughout.
- `pcD` = 0x3004, BR, `cmpOut` = 1, `offset` = 0xFFFF: next `pcF` = 0x3004. Same with `cmpOut` = 0: next `pcF` = previous `pcF` + 4.
- `pcD` = 0x3008, J, `instrIndex` = 0x0000C03: next `pcF` = 0x300C; `pcLink` = 0x3010.
- JR with `regTarget` = 0x3002: next `pcF` = 0x3002, `adelF` = 1. Then JR with `regTarget` = 0x2FFC: `adelF` = 1. Then JR with `regTarget` = 0x3000: `adelF` = 0.
- `stall` = 1 with BR taken for 2 cycles: `pcF` is unchanged. Then `excReq` = 1 with `stall` = 1: next `pcF` = 0x4180, `flushD` = 1 for one cycle only. With `NPC_EXC_EN` undefined, the same stimulus holds `pcF`.
- `eretReq` = 1 with `epc` = 0x3010 simultaneous with `excReq` = 1: `pcF` = 0x4180. `reset` = 0 during `stall`: `pcF` = 0x3000 next cycle.
